ecc_word_ram: RTL and testbench
===============================

Name: ecc_word_ram

Overview:
- Parametrised simple dual-port storage array for ECC codewords (data + parity), the successor to the fixed 39x16 codeword memory behind the ECC-protected FIFO.
- Generalised width and depth; optional output pipeline stage; read-valid flag; write-first collision bypass.
- Post-reset zero-initialisation sweep, so every location holds a valid all-zero SECDED codeword before first use.

Parameters:
- WIDTH, 39, codeword width in bits (data + check bits); legal range 2..256.
- DEPTH, 16, number of words; power of two, at least 2.
- ADDR_W, 4, address width; must equal clog2(DEPTH); elaboration error otherwise.
- OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, read latency 2 cycles.

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- rst_n  in  1  asynchronous active-low reset; deassertion synchronised upstream.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_word  in  WIDTH  codeword to store.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_word  out  WIDTH  registered read data.
- rd_valid  out  1  one-cycle pulse; rd_word holds the requested word.
- init_done  out  1  high once the zero sweep is complete; stays high until the next reset.
- req_drop  out  1  one-cycle pulse when a wr_en or rd_en is ignored during the sweep.

Behaviour:
- Reset (rst_n low, asynchronous): rd_word=0, rd_valid=0, init_done=0, req_drop=0, sweep pointer=0, FSM enters INIT.
  - Array contents are not reset asynchronously.
  - Pipeline registers (OUT_REG=1) also clear to 0.
- FSM INIT: one location per clk is written with all-zeros, address 0 to DEPTH-1.
  - After the write to DEPTH-1, the FSM moves to READY.
  - init_done rises on the edge that completes the last write, i.e. the DEPTH-th rising edge after rst_n release.
- In INIT: wr_en and rd_en are ignored and no array write or read occurs from the ports; rd_valid stays 0.
  - req_drop is registered: it is high in the cycle after any cycle with (wr_en|rd_en) & !init_done.
- FSM READY: steady state; leaves only on reset.
  - Reset asserted mid-sweep or mid-operation restarts INIT from address 0. In-flight reads are discarded (rd_valid=0).
- Write (READY): mem[wr_addr] <= wr_word on the edge where wr_en=1.
- Read (READY), OUT_REG=0: on an edge with rd_en=1, rd_word <= mem[rd_addr] and rd_valid <= 1.
  - Otherwise rd_valid <= 0 and rd_word holds its last value.
- Read, OUT_REG=1: the stage-1 capture is as above. Stage 2 registers both data and valid, so rd_word/rd_valid appear one cycle later.
  - Back-to-back reads run at full throughput, one per cycle.
- Collision (wr_en & rd_en & wr_addr==rd_addr in the same cycle): write-first; the read returns the new wr_word.
  - A write one cycle after a read's stage-1 capture does not alter that read's data.
- Address wrap: none internally; every address 0..DEPTH-1 is legal. The upstream FIFO owns pointer wrap.
- No handshake back-pressure: every READY request completes with fixed latency.

Optional Feature:
- Macro: ECC_WORD_RAM_ERR_INJ_EN.
- Defined: adds ports inj_en (in, 1) and inj_mask (in, WIDTH).
  - Any READY write with inj_en=1 stores wr_word ^ inj_mask.
  - The collision bypass returns the same corrupted value.
  - Used to exercise SEC/DED in the decoder.
- Undefined: ports absent; the stored word always equals wr_word. Zero-sweep words are never corrupted.

Test Plan:
- Reset release, DEPTH=16: init_done rises exactly 16 edges after rst_n release. Then read every address -> rd_word=0 with rd_valid pulsing, latency 1.
- Write addr 3 = 0x12_3456_789A (WIDTH=39), read addr 3 next cycle -> rd_word=0x12_3456_789A one edge later. Rerun with OUT_REG=1 -> same value two edges later.
- Same-cycle write addr 5 = 0x7F_FFFF_FFFF and read addr 5 -> rd_word=0x7F_FFFF_FFFF (write-first).
- Assert wr_en/rd_en at cycle 2 of the sweep -> req_drop pulses one cycle later, no rd_valid. Sweep still completes and the targeted address reads 0.
- Write addrs 0..15, pulse rst_n low mid-stream -> outputs clear immediately, init_done=0, sweep restarts; all reads after re-init return 0.
- ECC_WORD_RAM_ERR_INJ_EN defined: write addr 7 = 0x00_0000_00FF with inj_mask=0x00_0000_0001 -> read returns 0x00_0000_00FE. With inj_en=0, the same write reads back 0x00_0000_00FF.

Source files
------------

// File: rtl/ecc_word_ram.sv
// Simple dual-port ECC codeword RAM with a post-reset zero sweep, write-first bypass and optional output stage.
// Optional error injection ports are enabled by defining ECC_WORD_RAM_ERR_INJ_EN.
module ecc_word_ram #(
  parameter int unsigned WIDTH   = 39,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned OUT_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_word,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
`ifdef ECC_WORD_RAM_ERR_INJ_EN
  input  logic              inj_en,
  input  logic [WIDTH-1:0]  inj_mask,
`endif
  output logic [WIDTH-1:0]  rd_word,
  output logic              rd_valid,
  output logic              init_done,
  output logic              req_drop
);

  if (ADDR_W != $clog2(DEPTH)) begin : g_bad_addr_w
    $error("ecc_word_ram: ADDR_W must equal clog2(DEPTH)");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("ecc_word_ram: DEPTH must be a power of two >= 2");
  end
  if ((WIDTH < 2) || (WIDTH > 256)) begin : g_bad_width
    $error("ecc_word_ram: WIDTH must be in 2..256");
  end

  localparam logic [0:0]        ST_INIT   = 1'b0;
  localparam logic [0:0]        ST_READY  = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [0:0]        r_state;
  logic [0:0]        w_state_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_next;
  logic              r_init_done;
  logic              r_req_drop;
  logic [WIDTH-1:0]  r_rd1_word;
  logic              r_rd1_valid;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [WIDTH-1:0]  w_mem_data;
  logic              w_rd_fire;
  logic              w_collide;
  logic [WIDTH-1:0]  w_wr_data;

`ifdef ECC_WORD_RAM_ERR_INJ_EN
  assign w_wr_data = inj_en ? (wr_word ^ inj_mask) : wr_word;
`else
  assign w_wr_data = wr_word;
`endif

  assign w_collide = wr_en && (wr_addr == rd_addr);

  // Sweep zeros through the array, then hand the write port to the user
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_mem_we     = 1'b0;
    w_mem_addr   = wr_addr;
    w_mem_data   = w_wr_data;
    w_rd_fire    = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_mem_we   = 1'b1;
        w_mem_addr = r_ptr;
        w_mem_data = '0;
        w_ptr_next = r_ptr + ADDR_W'(1);
        if (r_ptr == LAST_ADDR) begin
          w_state_next = ST_READY;
        end
      end
      ST_READY: begin
        w_mem_we  = wr_en;
        w_rd_fire = rd_en;
      end
      default: begin
        w_state_next = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_ptr       <= '0;
      r_init_done <= 1'b0;
      r_req_drop  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_ptr       <= w_ptr_next;
      r_init_done <= (w_state_next == ST_READY);
      r_req_drop  <= (wr_en || rd_en) && !r_init_done;
    end
  end

  // Storage is not reset; the sweep provides the known-good contents
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd1_word  <= '0;
      r_rd1_valid <= 1'b0;
    end else begin
      r_rd1_valid <= w_rd_fire;
      if (w_rd_fire) begin
        r_rd1_word <= w_collide ? w_wr_data : r_mem[rd_addr];
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [WIDTH-1:0] r_rd2_word;
    logic             r_rd2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rd2_word  <= '0;
        r_rd2_valid <= 1'b0;
      end else begin
        r_rd2_word  <= r_rd1_word;
        r_rd2_valid <= r_rd1_valid;
      end
    end

    assign rd_word  = r_rd2_word;
    assign rd_valid = r_rd2_valid;
  end else begin : g_no_out_reg
    assign rd_word  = r_rd1_word;
    assign rd_valid = r_rd1_valid;
  end

  assign init_done = r_init_done;
  assign req_drop  = r_req_drop;

endmodule

// File: tb/tb_ecc_word_ram.sv
// Bench for ecc_word_ram: drives two instances (latency 1 and latency 2) from shared stimulus
// and checks both against an abstract memory model.
module tb_ecc_word_ram;

  localparam int unsigned WIDTH  = 39;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_word;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
`ifdef ECC_WORD_RAM_ERR_INJ_EN
  logic              inj_en;
  logic [WIDTH-1:0]  inj_mask;
`endif
  logic [WIDTH-1:0]  rd_word0, rd_word1;
  logic              rd_valid0, rd_valid1;
  logic              init_done0, init_done1;
  logic              req_drop0, req_drop1;

  int n_checks = 0;
  int n_errors = 0;

  // Abstract model: contents, sweep progress and expected outputs
  logic [WIDTH-1:0] m_mem [DEPTH];
  logic             m_init;
  int               m_cnt;
  logic             e_v1, e_v2, e_drop;
  logic [WIDTH-1:0] e_w1, e_w2;

  always #5 clk = ~clk;

  ecc_word_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OUT_REG(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_word(wr_word),
    .rd_en(rd_en), .rd_addr(rd_addr),
`ifdef ECC_WORD_RAM_ERR_INJ_EN
    .inj_en(inj_en), .inj_mask(inj_mask),
`endif
    .rd_word(rd_word0), .rd_valid(rd_valid0), .init_done(init_done0), .req_drop(req_drop0)
  );

  ecc_word_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OUT_REG(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_word(wr_word),
    .rd_en(rd_en), .rd_addr(rd_addr),
`ifdef ECC_WORD_RAM_ERR_INJ_EN
    .inj_en(inj_en), .inj_mask(inj_mask),
`endif
    .rd_word(rd_word1), .rd_valid(rd_valid1), .init_done(init_done1), .req_drop(req_drop1)
  );

  task automatic idle();
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_addr = '0;
    rd_addr = '0;
    wr_word = '0;
`ifdef ECC_WORD_RAM_ERR_INJ_EN
    inj_en   = 1'b0;
    inj_mask = '0;
`endif
  endtask

  task automatic model_reset();
    m_init = 1'b0;
    m_cnt  = 0;
    e_v1   = 1'b0;
    e_v2   = 1'b0;
    e_w1   = '0;
    e_w2   = '0;
    e_drop = 1'b0;
  endtask

  // Advance one clock, updating the model from the inputs present at the edge
  task automatic step();
    logic [WIDTH-1:0] wdata;
    logic             nv;
    logic [WIDTH-1:0] nw;
    wdata = wr_word;
`ifdef ECC_WORD_RAM_ERR_INJ_EN
    if (inj_en) wdata = wr_word ^ inj_mask;
`endif
    e_drop = (wr_en || rd_en) && !m_init;
    nv = 1'b0;
    nw = e_w1;
    if (m_init && rd_en) begin
      nv = 1'b1;
      nw = (wr_en && (wr_addr == rd_addr)) ? wdata : m_mem[rd_addr];
    end
    e_v2 = e_v1;
    e_w2 = e_w1;
    e_v1 = nv;
    e_w1 = nw;
    if (m_init && wr_en) m_mem[wr_addr] = wdata;
    if (!m_init) begin
      m_cnt++;
      if (m_cnt == DEPTH) begin
        m_init = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    #13;
    n_checks++;
    if (rd_word0 !== '0 || rd_valid0 !== 1'b0 || init_done0 !== 1'b0 || req_drop0 !== 1'b0 ||
        rd_word1 !== '0 || rd_valid1 !== 1'b0 || init_done1 !== 1'b0 || req_drop1 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: got w0=%h v0=%b d0=%b q0=%b w1=%h v1=%b d1=%b q1=%b, want all zero",
               rd_word0, rd_valid0, init_done0, req_drop0, rd_word1, rd_valid1, init_done1, req_drop1);
    end
    release_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      step();
      n_checks++;
      if (init_done0 !== (i == DEPTH) || init_done1 !== (i == DEPTH)) begin
        n_errors++;
        $display("FAIL init_done_edge %0d: got %b/%b, want %b", i, init_done0, init_done1, i == DEPTH);
      end
    end
    for (int a = 0; a <= DEPTH; a++) begin
      rd_en   = (a < DEPTH);
      rd_addr = ADDR_W'(a);
      step();
      n_checks++;
      if (rd_word0 !== e_w1 || rd_valid0 !== e_v1 || rd_word1 !== e_w2 || rd_valid1 !== e_v2) begin
        n_errors++;
        $display("FAIL zero_read %0d: got %h/%b %h/%b, want %h/%b %h/%b", a,
                 rd_word0, rd_valid0, rd_word1, rd_valid1, e_w1, e_v1, e_w2, e_v2);
      end
      if (a < DEPTH) begin
        n_checks++;
        if (rd_word0 !== '0 || rd_valid0 !== 1'b1) begin
          n_errors++;
          $display("FAIL zero_read_lat1 %0d: got %h/%b, want 0/1", a, rd_word0, rd_valid0);
        end
      end
    end
    idle();
  endtask

  task automatic test_write_read();
    logic [WIDTH-1:0] val;
    val     = 39'h12_3456_789A;
    wr_en   = 1'b1;
    wr_addr = 4'd3;
    wr_word = val;
    step();
    idle();
    rd_en   = 1'b1;
    rd_addr = 4'd3;
    step();
    n_checks++;
    if (rd_word0 !== val || rd_valid0 !== 1'b1 || rd_valid1 !== 1'b0) begin
      n_errors++;
      $display("FAIL write_read_lat1: got %h/%b (lat2 v=%b), want %h/1 (lat2 v=0)",
               rd_word0, rd_valid0, rd_valid1, val);
    end
    idle();
    step();
    n_checks++;
    if (rd_word1 !== val || rd_valid1 !== 1'b1 || rd_valid0 !== 1'b0 || rd_word0 !== val) begin
      n_errors++;
      $display("FAIL write_read_lat2: got %h/%b (lat1 %h/%b), want %h/1 (lat1 held, v=0)",
               rd_word1, rd_valid1, rd_word0, rd_valid0, val);
    end
  endtask

  task automatic test_collision();
    logic [WIDTH-1:0] val;
    val     = 39'h7F_FFFF_FFFF;
    wr_en   = 1'b1;
    wr_addr = 4'd5;
    wr_word = val;
    rd_en   = 1'b1;
    rd_addr = 4'd5;
    step();
    n_checks++;
    if (rd_word0 !== val || rd_valid0 !== 1'b1) begin
      n_errors++;
      $display("FAIL collision_lat1: got %h/%b, want %h/1", rd_word0, rd_valid0, val);
    end
    // Read then overwrite next cycle: latency-2 copy must keep the old data
    wr_word = 39'h00_0000_1111;
    rd_en   = 1'b0;
    step();
    n_checks++;
    if (rd_word1 !== val || rd_valid1 !== 1'b1) begin
      n_errors++;
      $display("FAIL collision_lat2: got %h/%b, want %h/1", rd_word1, rd_valid1, val);
    end
    idle();
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      wr_en   = 1'($urandom);
      rd_en   = 1'($urandom);
      wr_addr = ($urandom % 2 == 0) ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom);
      rd_addr = ($urandom % 2 == 0) ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom);
      wr_word = WIDTH'({$urandom, $urandom});
      step();
      n_checks++;
      if (rd_word0 !== e_w1 || rd_valid0 !== e_v1 || rd_word1 !== e_w2 || rd_valid1 !== e_v2 ||
          req_drop0 !== e_drop || req_drop1 !== e_drop) begin
        n_errors++;
        $display("FAIL random cyc %0d: got %h/%b %h/%b drop %b/%b, want %h/%b %h/%b drop %b", c,
                 rd_word0, rd_valid0, rd_word1, rd_valid1, req_drop0, req_drop1,
                 e_w1, e_v1, e_w2, e_v2, e_drop);
      end
    end
    idle();
    step();
    step();
  endtask

  task automatic test_init_drop();
    rst_n = 1'b0;
    model_reset();
    #2;
    release_reset();
    step();
    wr_en   = 1'b1;
    wr_addr = 4'd9;
    wr_word = 39'h55_AAAA_5555;
    rd_en   = 1'b1;
    rd_addr = 4'd9;
    step();
    n_checks++;
    if (req_drop0 !== 1'b1 || req_drop1 !== 1'b1 || rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0) begin
      n_errors++;
      $display("FAIL drop_pulse: got drop %b/%b valid %b/%b, want drop 1 valid 0",
               req_drop0, req_drop1, rd_valid0, rd_valid1);
    end
    idle();
    step();
    n_checks++;
    if (req_drop0 !== 1'b0 || rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0) begin
      n_errors++;
      $display("FAIL drop_clear: got drop %b valid %b/%b, want 0 0/0", req_drop0, rd_valid0, rd_valid1);
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (!m_init) step();
    end
    n_checks++;
    if (init_done0 !== 1'b1 || init_done1 !== 1'b1 || m_init !== 1'b1) begin
      n_errors++;
      $display("FAIL drop_sweep_done: got %b/%b, want 1", init_done0, init_done1);
    end
    rd_en   = 1'b1;
    rd_addr = 4'd9;
    step();
    idle();
    n_checks++;
    if (rd_word0 !== '0 || rd_valid0 !== 1'b1) begin
      n_errors++;
      $display("FAIL drop_addr_zero: got %h/%b, want 0/1", rd_word0, rd_valid0);
    end
    step();
  endtask

  task automatic test_reset_midstream();
    for (int a = 0; a < DEPTH; a++) begin
      wr_en   = 1'b1;
      wr_addr = ADDR_W'(a);
      wr_word = WIDTH'({$urandom, $urandom}) | WIDTH'(1);
      rd_en   = (a > 0);
      rd_addr = ADDR_W'(a - 1);
      if (a == 9) break;
      step();
    end
    #3;
    rst_n = 1'b0;
    idle();
    model_reset();
    #1;
    n_checks++;
    if (rd_word0 !== '0 || rd_valid0 !== 1'b0 || rd_word1 !== '0 || rd_valid1 !== 1'b0 ||
        init_done0 !== 1'b0 || init_done1 !== 1'b0) begin
      n_errors++;
      $display("FAIL midstream_reset: got %h/%b %h/%b done %b/%b, want all zero",
               rd_word0, rd_valid0, rd_word1, rd_valid1, init_done0, init_done1);
    end
    release_reset();
    for (int i = 0; i < DEPTH + DEPTH + 2; i++) begin
      if (m_init && i >= DEPTH) begin
        rd_en   = (i < DEPTH + DEPTH);
        rd_addr = ADDR_W'(i - DEPTH);
      end
      step();
      n_checks++;
      if (rd_word0 !== e_w1 || rd_valid0 !== e_v1 || rd_word1 !== e_w2 || rd_valid1 !== e_v2 ||
          init_done0 !== m_init || init_done1 !== m_init) begin
        n_errors++;
        $display("FAIL reinit %0d: got %h/%b %h/%b done %b, want %h/%b %h/%b done %b", i,
                 rd_word0, rd_valid0, rd_word1, rd_valid1, init_done0, e_w1, e_v1, e_w2, e_v2, m_init);
      end
    end
    idle();
    step();
  endtask

`ifdef ECC_WORD_RAM_ERR_INJ_EN
  task automatic test_err_inj();
    wr_en    = 1'b1;
    wr_addr  = 4'd7;
    wr_word  = 39'h00_0000_00FF;
    inj_en   = 1'b1;
    inj_mask = 39'h00_0000_0001;
    step();
    idle();
    rd_en   = 1'b1;
    rd_addr = 4'd7;
    step();
    n_checks++;
    if (rd_word0 !== 39'h00_0000_00FE || rd_valid0 !== 1'b1) begin
      n_errors++;
      $display("FAIL inj_on: got %h/%b, want 00000000fe/1", rd_word0, rd_valid0);
    end
    idle();
    wr_en   = 1'b1;
    wr_addr = 4'd7;
    wr_word = 39'h00_0000_00FF;
    step();
    idle();
    rd_en   = 1'b1;
    rd_addr = 4'd7;
    step();
    n_checks++;
    if (rd_word0 !== 39'h00_0000_00FF) begin
      n_errors++;
      $display("FAIL inj_off: got %h, want 00000000ff", rd_word0);
    end
    wr_en    = 1'b1;
    wr_addr  = 4'd7;
    wr_word  = 39'h00_0000_00F0;
    inj_en   = 1'b1;
    inj_mask = 39'h40_0000_0000;
    step();
    n_checks++;
    if (rd_word0 !== 39'h40_0000_00F0) begin
      n_errors++;
      $display("FAIL inj_bypass: got %h, want 40000000f0", rd_word0);
    end
    idle();
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_random();
    test_init_drop();
    test_reset_midstream();
`ifdef ECC_WORD_RAM_ERR_INJ_EN
    test_err_inj();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
